// File: rtl/p3to3_seq_if.sv
// Host and datapath signal bundle for the p3to3 neuron sequencer.
// The sequencer sits on the slave side; the host plus external datapath sit on the master side.
interface p3to3_seq_if #(
    parameter int N = 8
);
    logic           start_in;
    logic           dir_in;
    logic [N-1:0]   fcontrol_in;
    logic [3*N-1:0] fin_in;
    logic [3*N-1:0] bin_in;
    logic           ready_out;
    logic           done_out;
    logic [N-1:0]   fout_out;
    logic [N-1:0]   bout_out;
    logic [N-1:0]   bcontrol_out;
    logic           dp_fcontrol_out;
    logic [2:0]     dp_fin_out;
    logic [2:0]     dp_bin_out;
    logic           dp_fout_in;
    logic           dp_bout_in;
    logic           dp_bcontrol_in;

    modport master (
        output start_in, dir_in, fcontrol_in, fin_in, bin_in,
        output dp_fout_in, dp_bout_in, dp_bcontrol_in,
        input  ready_out, done_out, fout_out, bout_out, bcontrol_out,
        input  dp_fcontrol_out, dp_fin_out, dp_bin_out
    );

    modport slave (
        input  start_in, dir_in, fcontrol_in, fin_in, bin_in,
        input  dp_fout_in, dp_bout_in, dp_bcontrol_in,
        output ready_out, done_out, fout_out, bout_out, bcontrol_out,
        output dp_fcontrol_out, dp_fin_out, dp_bin_out
    );
endinterface

// File: rtl/p3to3_seq.sv
// Time-multiplexes N neurons onto one external p3to3 datapath, one neuron per cycle,
// collecting forward or backward results into per-neuron output registers.
module p3to3_seq #(
    parameter int N = 8
) (
    input  logic         clk_in,
    input  logic         rst_in_n,
    p3to3_seq_if.slave   bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nx;
    logic [IW-1:0]  idx;
    logic           dir_q;
    logic           armed;
    logic [N-1:0]   fc_q;
    logic [3*N-1:0] fin_q;
    logic [3*N-1:0] bin_q;
    logic           accept;
    logic           last;

    always_comb begin
        state_nx            = state;
        last                = (idx == LAST);
        bus.ready_out       = (state != RUN);
        bus.done_out        = (state == DONE);
        bus.dp_fcontrol_out = 1'b0;
        bus.dp_fin_out      = 3'b000;
        bus.dp_bin_out      = 3'b000;
        // armed keeps the first edge after reset release from taking a start
        accept              = bus.start_in && bus.ready_out && armed;
        unique case (state)
            IDLE: if (accept) state_nx = RUN;
            RUN: begin
                bus.dp_fcontrol_out = fc_q[idx];
                bus.dp_fin_out      = fin_q[3*idx +: 3];
                bus.dp_bin_out      = bin_q[3*idx +: 3];
                if (last) state_nx = DONE;
            end
            DONE:    state_nx = accept ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state            <= IDLE;
            idx              <= '0;
            dir_q            <= 1'b0;
            armed            <= 1'b0;
            fc_q             <= '0;
            fin_q            <= '0;
            bin_q            <= '0;
            bus.fout_out     <= '0;
            bus.bout_out     <= '0;
            bus.bcontrol_out <= '0;
        end else begin
            state <= state_nx;
            armed <= 1'b1;
            if (accept) begin
                dir_q <= bus.dir_in;
                fc_q  <= bus.fcontrol_in;
                fin_q <= bus.fin_in;
                bin_q <= bus.bin_in;
                idx   <= '0;
            end else if (state == RUN) begin
                if (dir_q) begin
                    bus.bout_out[idx]     <= bus.dp_bout_in;
                    bus.bcontrol_out[idx] <= bus.dp_bcontrol_in;
                end else begin
                    bus.fout_out[idx] <= bus.dp_fout_in;
                end
                idx <= last ? '0 : idx + 1'b1;
            end
        end
    end
endmodule

// File: doc/p3to3_seq.md
P3TO3_SEQ -- requirements
Module: p3to3_seq

Interface
REQ-001 SHALL have parameter N, default 8, the number of neurons time-multiplexed onto one external p3to3 datapath (N >= 2).
REQ-002 SHALL have port clk_in  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_in_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start_in  input  1  request to begin a layer pass.
REQ-005 SHALL have port dir_in  input  1  pass direction: 0 = forward, 1 = backward.
REQ-006 SHALL have port fcontrol_in  input  N  per-neuron forward control bit.
REQ-007 SHALL have port fin_in  input  3N  forward operands; neuron i uses bits [3i+2:3i].
REQ-008 SHALL have port bin_in  input  3N  backward operands; neuron i uses bits [3i+2:3i].
REQ-009 SHALL have port ready_out  output  1  high when start_in will be accepted.
REQ-010 SHALL have port done_out  output  1  one-cycle pulse when a pass completes.
REQ-011 SHALL have port fout_out  output  N  forward results, one bit per neuron.
REQ-012 SHALL have port bout_out  output  N  backward results, one bit per neuron.
REQ-013 SHALL have port bcontrol_out  output  N  backward control results, one bit per neuron.
REQ-014 SHALL have port dp_fcontrol_out  output  1  control bit driven to the datapath.
REQ-015 SHALL have port dp_fin_out  output  3  forward operands driven to the datapath.
REQ-016 SHALL have port dp_bin_out  output  3  backward operands driven to the datapath.
REQ-017 SHALL have port dp_fout_in  input  1  forward result returned by the datapath, combinational in the same cycle.
REQ-018 SHALL have port dp_bout_in  input  1  backward result returned by the datapath.
REQ-019 SHALL have port dp_bcontrol_in  input  1  backward control result returned by the datapath.

Function
REQ-020 SHALL implement states IDLE, RUN and DONE, plus a ceil(log2 N)-bit index idx and a registered direction bit dir_q.
REQ-021 SHALL drive ready_out high in IDLE and DONE, and low in RUN.
REQ-022 SHALL accept a start when start_in and ready_out are both high at a clock edge:
  - latch dir_in, fcontrol_in, fin_in and bin_in into internal operand registers;
  - set idx to 0 and move to RUN.
REQ-023 SHALL make the latched operands the only source for the pass; input changes after acceptance have no effect.
REQ-024 SHALL ignore start_in in RUN, with no effect on state, idx or results.
REQ-025 SHALL, in RUN, drive the datapath with neuron idx's latched operands:
  - dp_fcontrol_out = fcontrol[idx];
  - dp_fin_out = fin[3idx+2:3idx];
  - dp_bin_out = bin[3idx+2:3idx].
REQ-026 SHALL, at each RUN edge with dir_q = 0, write dp_fout_in into fout_out[idx] and leave bout_out and bcontrol_out unchanged.
REQ-027 SHALL, at each RUN edge with dir_q = 1, write dp_bout_in into bout_out[idx] and dp_bcontrol_in into bcontrol_out[idx], and leave fout_out unchanged.
REQ-028 SHALL increment idx at each RUN edge, and move to DONE at the edge where idx = N-1 instead of wrapping.
REQ-029 SHALL take exactly N cycles in RUN; done_out asserts N+1 cycles after the accepting edge.
REQ-030 SHALL assert done_out only in DONE; DONE lasts one cycle.
REQ-031 SHALL leave DONE for RUN if a start is accepted in that cycle (back-to-back passes, no idle bubble), otherwise for IDLE.
REQ-032 SHALL hold fout_out, bout_out and bcontrol_out stable outside RUN until overwritten by a later pass.
REQ-033 SHALL drive dp_fcontrol_out, dp_fin_out and dp_bin_out to 0 in IDLE and DONE.

Reset
REQ-034 SHALL, while rst_in_n is low, immediately force:
  - state to IDLE and idx to 0;
  - dir_q, the operand registers, fout_out, bout_out and bcontrol_out to 0;
  - done_out to 0 and ready_out to 1.
REQ-035 SHALL abandon any pass in progress when reset is asserted mid-RUN: no done_out pulse and no partial results retained.
REQ-036 SHALL accept no start at the first clock edge after rst_in_n deasserts; start acceptance resumes at the second edge.

Verification
REQ-037 SHALL pass a forward test with N=4 and a datapath model (majority of control and the three inputs; ties resolved as in maj_gate):
  - start with dir_in=0, fcontrol_in=4'b0101, fin_in=12'b111_000_110_001;
  - required: done_out 5 cycles after acceptance, fout_out matches the model per neuron, bout_out = 0.
REQ-038 SHALL pass a backward test: dir_in=1, bin_in=12'b011_100_111_000 -> bout_out = bcontrol_out = 4'b1010, fout_out unchanged from the previous pass.
REQ-039 SHALL pass a back-to-back test: start held high through DONE -> second pass begins with no IDLE cycle and done_out pulses at cycles 5 and 10.
REQ-040 SHALL pass an ignored-start test: start_in pulsed at RUN cycle 2 with different operands -> results reflect only the first operands, and only one done_out pulse occurs.
REQ-041 SHALL pass a mid-pass reset test: rst_in_n low at RUN cycle 2 -> outputs 0 and ready_out = 1 immediately, no done_out pulse, and a new pass after release completes correctly.
